// File: rtl/baud_gen.sv
// baud_gen: programmable 16x/1x baud tick generator with shadowed 8250-style divisor latch.
//   clkin, rst_n (async, active low); enable, restart; div_we/div_sel/div_wdata byte writes;
//   divisor readback, halted, tick16/tick pulses, clk16_sq/clk_sq square waves.
module baud_gen #(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 177
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             div_we,
  input  logic             div_sel,
  input  logic [7:0]       div_wdata,
  output logic [DIV_W-1:0] divisor,
  output logic             halted,
  output logic             tick16,
  output logic             tick,
  output logic             clk16_sq,
  output logic             clk_sq
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  logic [DIV_W-1:0] r_shadow, r_live, r_div_cnt;
  logic [OS_W-1:0]  r_os_cnt;
  logic             w_div_tc, w_os_tc, w_shadow_nz;
  assign w_div_tc    = r_div_cnt == '0;
  assign w_os_tc     = r_os_cnt == '0;
  assign w_shadow_nz = r_shadow != '0;
  assign divisor     = r_shadow;
  assign halted      = r_live == '0;
  // live/div_cnt always reload from the pre-write shadow, so a byte written on a
  // terminal-count or restart edge only applies at the following reload.
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      r_shadow  <= DEF_DIV;
      r_live    <= DEF_DIV;
      r_div_cnt <= DEF_DIV - 1'b1;
      r_os_cnt  <= OS_LAST;
      tick16    <= 1'b0;
      tick      <= 1'b0;
      clk16_sq  <= 1'b0;
      clk_sq    <= 1'b0;
    end else begin
      if (div_we && div_sel) r_shadow[DIV_W-1:8] <= div_wdata[DIV_W-9:0];
      if (div_we && !div_sel) r_shadow[7:0] <= div_wdata;
      tick16 <= 1'b0;
      tick   <= 1'b0;
      if (restart) begin
        r_live    <= r_shadow;
        r_div_cnt <= r_shadow - 1'b1;
        r_os_cnt  <= OS_LAST;
        clk16_sq  <= 1'b0;
        clk_sq    <= 1'b0;
      end else if (halted) begin
        // leave halt as soon as software has put a nonzero divisor in the shadow
        if (w_shadow_nz) begin
          r_live    <= r_shadow;
          r_div_cnt <= r_shadow - 1'b1;
        end
      end else if (enable) begin
        if (w_div_tc) begin
          tick16    <= 1'b1;
          clk16_sq  <= ~clk16_sq;
          r_live    <= r_shadow;
          r_div_cnt <= r_shadow - 1'b1;
          tick      <= w_os_tc;
          clk_sq    <= clk_sq ^ w_os_tc;
          r_os_cnt  <= w_os_tc ? OS_LAST : r_os_cnt - 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt - 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: randomized and directed self-checking bench for baud_gen against a period-level model.
module tb_baud_gen;
  localparam int DIV_W = 16;
  localparam int OS = 16;
  logic clkin = 1'b0, rst_n = 1'b0, enable = 1'b0, restart = 1'b0, div_we = 1'b0, div_sel = 1'b0;
  logic [7:0] div_wdata = 8'h0;
  logic [DIV_W-1:0] divisor;
  logic halted, tick16, tick, clk16_sq, clk_sq;
  int checks = 0, failures = 0;
  int m_shadow, m_live, m_elapsed, m_n16;
  bit m_t16, m_t, m_s16, m_s;
  baud_gen #(.DIV_W(DIV_W), .OVERSAMPLE(OS), .DEFAULT_DIV(177)) dut (
    .clkin(clkin), .rst_n(rst_n), .enable(enable), .restart(restart), .div_we(div_we),
    .div_sel(div_sel), .div_wdata(div_wdata), .divisor(divisor), .halted(halted),
    .tick16(tick16), .tick(tick), .clk16_sq(clk16_sq), .clk_sq(clk_sq));
  always #5 clkin = ~clkin;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: count enabled cycles since the period began; a period ends when that count reaches live.
  always @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      m_shadow = 177; m_live = 177; m_elapsed = 0; m_n16 = 0;
      m_t16 = 0; m_t = 0; m_s16 = 0; m_s = 0;
    end else begin
      int nsh;
      nsh = m_shadow;
      if (div_we) nsh = div_sel ? ((int'(div_wdata) & ((1 << (DIV_W - 8)) - 1)) << 8) | (m_shadow & 255)
                                : (m_shadow & ~255) | int'(div_wdata);
      m_t16 = 0; m_t = 0;
      if (restart) begin
        m_live = m_shadow; m_elapsed = 0; m_n16 = 0; m_s16 = 0; m_s = 0;
      end else if (m_live == 0) begin
        if (m_shadow != 0) begin m_live = m_shadow; m_elapsed = 0; end
      end else if (enable) begin
        m_elapsed++;
        if (m_elapsed == m_live) begin
          m_t16 = 1; m_s16 = !m_s16; m_elapsed = 0; m_live = m_shadow; m_n16++;
          if (m_n16 == OS) begin m_t = 1; m_s = !m_s; m_n16 = 0; end
        end
      end
      m_shadow = nsh;
    end
  always @(negedge clkin) begin
    chk("tick16", int'(tick16), int'(m_t16));
    chk("tick", int'(tick), int'(m_t));
    chk("clk16_sq", int'(clk16_sq), int'(m_s16));
    chk("clk_sq", int'(clk_sq), int'(m_s));
    chk("halted", int'(halted), int'(m_live == 0));
    chk("divisor", int'(divisor), m_shadow);
  end
  task automatic wr(input bit sel, input int data);
    div_we = 1; div_sel = sel; div_wdata = 8'(data);
    @(negedge clkin);
    div_we = 0;
  endtask
  task automatic wait_sig(input bit sel_tick, input int max, output int n);
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (!(sel_tick ? tick : tick16) && n < max);
    if (!(sel_tick ? tick : tick16)) begin
      failures++;
      $display("FAIL wait_%s: no pulse within %0d cycles", sel_tick ? "tick" : "tick16", max);
    end
  endtask
  initial begin
    int n, cnt;
    repeat (3) @(negedge clkin);
    chk("rst_divisor", int'(divisor), 177);
    chk("rst_tick16", int'(tick16), 0);
    chk("rst_halted", int'(halted), 0);
    rst_n = 1; enable = 1;
    wait_sig(1, 5000, n); chk("first_tick_latency", n, 2832);
    wait_sig(0, 500, n); chk("tick16_period_177", n, 177);
    wait_sig(0, 500, n); chk("tick16_period_177b", n, 177);
    repeat (50) @(negedge clkin);
    wr(0, 4); wr(1, 0);
    chk("divisor_4", int'(divisor), 4);
    wait_sig(0, 500, n); chk("old_period_intact", n + 52, 177);
    wait_sig(0, 500, n); chk("tick16_period_4", n, 4);
    wait_sig(0, 500, n); chk("tick16_period_4b", n, 4);
    wait_sig(1, 500, n);
    wait_sig(1, 500, n); chk("tick_period_64", n, 64);
    wr(0, 0);
    chk("divisor_0", int'(divisor), 0);
    wait_sig(0, 500, n);
    @(negedge clkin);
    chk("halted_set", int'(halted), 1);
    cnt = 0;
    repeat (1000) begin @(negedge clkin); cnt += int'(tick16); end
    chk("no_pulses_halted", cnt, 0);
    wr(0, 1);
    @(negedge clkin); chk("halted_clear", int'(halted), 0);
    @(negedge clkin); chk("div1_tick16", int'(tick16), 1);
    @(negedge clkin); chk("div1_tick16b", int'(tick16), 1);
    wait_sig(1, 100, n);
    wait_sig(1, 100, n); chk("tick_period_16", n, 16);
    wr(0, 10);
    wait_sig(0, 100, n); wait_sig(0, 100, n);
    repeat (3) @(negedge clkin);
    enable = 0;
    repeat (50) @(negedge clkin);
    enable = 1;
    wait_sig(0, 200, n); chk("enable_gap_delay", n + 53, 60);
    repeat ($urandom_range(0, 9)) @(negedge clkin);
    restart = 1; @(negedge clkin); restart = 0;
    chk("restart_tick16", int'(tick16), 0);
    chk("restart_sq16", int'(clk16_sq), 0);
    chk("restart_sq", int'(clk_sq), 0);
    wait_sig(0, 100, n); chk("restart_first_tick16", n, 10);
    repeat ($urandom_range(0, 9)) @(negedge clkin);
    restart = 1; @(negedge clkin); restart = 0;
    wait_sig(1, 500, n); chk("restart_first_tick", n, 160);
    wr(0, 4);
    repeat (21) @(negedge clkin);
    #3 rst_n = 0;
    #1;
    chk("async_tick16", int'(tick16), 0);
    chk("async_sq16", int'(clk16_sq), 0);
    chk("async_divisor", int'(divisor), 177);
    @(negedge clkin); rst_n = 1;
    @(negedge clkin); chk("post_reset_divisor", int'(divisor), 177);
    repeat (6000) begin
      enable = $urandom_range(0, 9) != 0;
      restart = $urandom_range(0, 149) == 0;
      div_we = $urandom_range(0, 9) == 0;
      div_sel = $urandom_range(0, 5) == 0;
      div_wdata = div_sel ? 8'($urandom_range(0, 1) * ($urandom_range(0, 3) == 0)) : 8'($urandom_range(0, 12));
      @(negedge clkin);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baud_gen.md
Name: baud_gen

Overview:
- Programmable baud-rate generator for the 8250 UART subsystem.
- Takes the system clock and produces a 16x-oversample enable and a 1x bit-rate enable, both as single-cycle pulses, plus 50%-duty square-wave versions of each.
- Divisor is software-loaded through an 8250-style low/high byte latch, with glitch-free retiming.
- Oversample ratio and divisor width are parameters; pulses are consumed by the transmitter and receiver shift logic on the same clock.

Parameters:
- DIV_W, 16, divisor width in bits. Legal range 9..16.
- OVERSAMPLE, 16, number of tick16 pulses per tick. Legal range 2..64; need not be a power of two.
- DEFAULT_DIV, 177, divisor loaded at reset into both the shadow and live divisor. Must be nonzero.

Ports:
- clkin  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  count enable. When low, counters hold and no pulses are issued.
- restart  input  1  synchronous restart of both counters (phase alignment).
- div_we  input  1  divisor byte write strobe.
- div_sel  input  1  byte select: 0 = low byte [7:0]; 1 = high byte [DIV_W-1:8].
- div_wdata  input  8  write data. For the high byte, only bits [DIV_W-9:0] are used.
- divisor  output  DIV_W  shadow divisor readback.
- halted  output  1  high while live divisor == 0.
- tick16  output  1  one-cycle pulse at 16x (oversample) rate.
- tick  output  1  one-cycle pulse at bit rate.
- clk16_sq  output  1  toggles on every tick16.
- clk_sq  output  1  toggles on every tick.

Behaviour:
- Reset (async, rst_n low):
  - shadow = live = DEFAULT_DIV; div_cnt = DEFAULT_DIV-1; os_cnt = OVERSAMPLE-1.
  - tick16, tick, clk16_sq, clk_sq, halted = 0; divisor = DEFAULT_DIV.
- Registers:
  - shadow[DIV_W-1:0]
  - live[DIV_W-1:0]
  - div_cnt[DIV_W-1:0], down-counter
  - os_cnt, width = clog2(OVERSAMPLE), down-counter
- Write:
  - div_we=1 updates only the selected shadow byte on the same edge; the other byte is unchanged.
  - divisor reflects the new value the next cycle.
  - Writes are never blocked.
- Divisor counting, on each edge with enable=1, restart=0, live!=0:
  - div_cnt != 0: div_cnt decrements.
  - div_cnt == 0: tick16=1 on the next cycle; live <= shadow; div_cnt <= shadow-1.
  - Net result: tick16 period is exactly live enabled cycles. Divisor 1 gives tick16 high on every enabled cycle.
  - A new divisor takes effect only at terminal count, so there is no truncated or runt period.
- Oversample counting, on each cycle in which a tick16 pulse is generated:
  - os_cnt == 0: tick=1 in the same cycle as that tick16; os_cnt <= OVERSAMPLE-1.
  - Otherwise os_cnt decrements.
  - tick is always coincident with a tick16 pulse; tick period = live*OVERSAMPLE cycles.
- Square waves:
  - clk16_sq inverts in the cycle tick16 is asserted.
  - clk_sq inverts in the cycle tick is asserted.
  - Periods are 2*live and 2*live*OVERSAMPLE cycles.
- Halt:
  - If live==0, counters hold, tick16/tick stay 0, halted=1.
  - While halted, a shadow write of a nonzero value loads live <= shadow and div_cnt <= shadow-1 on the edge after the write. halted drops that same cycle.
  - If shadow becomes 0 and is then loaded at terminal count, the generator halts after that final tick16.
- enable=0: all counters and square waves hold; tick16=tick=0; writes still accepted.
- restart=1 (priority over counting, below reset):
  - live <= shadow; div_cnt <= shadow-1; os_cnt <= OVERSAMPLE-1.
  - tick16=tick=0; square waves cleared to 0.
- Simultaneous events:
  - div_we at the terminal-count edge: live takes the pre-write shadow value; the new byte applies at the following terminal count.
  - restart with div_we: live takes the pre-write shadow.
- Reset mid-operation: all state returns to reset values immediately (async); no pulse is issued in the reset cycle.

Test Plan:
- Defaults, enable=1 after reset → first tick16 177 cycles after release, then every 177; tick every 2832 cycles; clk16_sq period 354; clk_sq period 5664.
- Write low=0x04, high=0x00 mid-period (live 177) → current 177-cycle period completes intact, then tick16 every 4 cycles; tick every 64.
- Write divisor 0 → halted=1 after the current terminal count, no pulses for 1000 cycles; write low=0x01 → halted=0, tick16 high every enabled cycle, tick every 16 cycles.
- enable low for 50 cycles mid-count → next tick16 delayed by exactly 50 cycles; square waves frozen.
- restart pulse at arbitrary phase with divisor 10 → tick16, tick, and square waves low; first tick16 exactly 10 cycles later; tick 160 cycles later.
- rst_n asserted during counting with divisor 4 → outputs zero asynchronously; divisor readback 177 after release.
